// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: I2C SCL clock generator with mid-phase ticks for SDA
// change/sample timing. Speeds 100 kHz / 400 kHz / 1 MHz derived from
// CLK_FREQ_HZ. Optional clock stretching support is built when the macro
// SCL_STRETCH_EN is defined; otherwise the low phase goes straight to
// the high phase and scl_in is ignored.
module i2c_scl_gen #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int STRETCH_TIMEOUT = 1_250_000
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       scl_in,
    output logic       scl_o,
    output logic       tick_low_mid,
    output logic       tick_high_mid,
    output logic       tick_fall,
    output logic       busy,
    output logic       stretch_timeout
);

    // Half-period lengths in CLK cycles; standard mode is the longest.
    localparam int HALF_SM = CLK_FREQ_HZ / (2 * 100_000);
    localparam int HALF_FM = CLK_FREQ_HZ / (2 * 400_000);
    localparam int HALF_FP = CLK_FREQ_HZ / (2 * 1_000_000);
    localparam int CW      = $clog2(HALF_SM) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH_WAIT,
        HIGH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] half_q;
    logic [CW-1:0] half_sel;
    logic [CW-1:0] last_cnt;
    logic [CW-1:0] mid_cnt;

`ifdef SCL_STRETCH_EN
    localparam int SW = $clog2(STRETCH_TIMEOUT + 1);

    logic [1:0]    sync_q;
    logic          scl_sync;
    logic [SW-1:0] stretch_cnt;
    logic          to_q;

    // Two-flop synchroniser for the external SCL level; idles released.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], scl_in};
        end
    end

    assign scl_sync        = sync_q[1];
    assign stretch_timeout = to_q;
`else
    logic unused_scl_in;

    assign unused_scl_in   = scl_in;
    assign stretch_timeout = 1'b0;
`endif

    // Map the speed select to a half-period; reserved code runs standard mode.
    always_comb begin
        case (mode)
            2'b01:   half_sel = CW'(HALF_FM);
            2'b10:   half_sel = CW'(HALF_FP);
            default: half_sel = CW'(HALF_SM);
        endcase
    end

    assign last_cnt = half_q - 1'b1;
    assign mid_cnt  = (half_q >> 1) - 1'b1;

    // Phase sequencer: the speed is latched on leaving IDLE, and an
    // en drop only takes effect at the end of a full high phase.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            half_q <= CW'(HALF_SM);
            scl_o  <= 1'b1;
`ifdef SCL_STRETCH_EN
            stretch_cnt <= '0;
            to_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef SCL_STRETCH_EN
                    if (!en) begin
                        to_q <= 1'b0;
                    end
`endif
                    if (en) begin
                        state  <= LOW;
                        scl_o  <= 1'b0;
                        half_q <= half_sel;
                    end
                end
                LOW: begin
                    if (cnt == last_cnt) begin
                        cnt   <= '0;
                        scl_o <= 1'b1;
`ifdef SCL_STRETCH_EN
                        state       <= HIGH_WAIT;
                        stretch_cnt <= '0;
`else
                        state <= HIGH;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH_WAIT: begin
`ifdef SCL_STRETCH_EN
                    if (scl_sync) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (stretch_cnt == SW'(STRETCH_TIMEOUT - 1)) begin
                        state <= IDLE;
                        to_q  <= 1'b1;
                        scl_o <= 1'b1;
                    end else begin
                        stretch_cnt <= stretch_cnt + 1'b1;
                    end
`else
                    state <= HIGH;
                    cnt   <= '0;
`endif
                end
                HIGH: begin
                    if (cnt == last_cnt) begin
                        cnt <= '0;
                        if (en) begin
                            state <= LOW;
                            scl_o <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ticks decode the registered phase position; the fall tick wins if a
    // very short half-period would put the low midpoint on count zero.
    always_comb begin
        tick_fall     = (state == LOW) && (cnt == '0);
        tick_low_mid  = (state == LOW) && (cnt == mid_cnt) && (cnt != '0);
        tick_high_mid = (state == HIGH) && (cnt == mid_cnt);
        busy          = (state != IDLE);
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: per-mode period table plus hand-written
// sequences for mode latching, en drop, reset and clock stretching.
module tb_i2c_scl_gen;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       hold_low = 1'b0;
    logic       scl_in;
    logic       scl_o;
    logic       tick_low_mid;
    logic       tick_high_mid;
    logic       tick_fall;
    logic       busy;
    logic       stretch_timeout;

    int n_vec = 0;
    int n_bad = 0;

`ifdef SCL_STRETCH_EN
    localparam int HW = 3;
`else
    localparam int HW = 0;
`endif

    // Open-drain loopback with an external device able to hold SCL low.
    assign scl_in = scl_o & ~hold_low;

    always #5 CLK = ~CLK;

    i2c_scl_gen #(
        .CLK_FREQ_HZ    (50_000_000),
        .STRETCH_TIMEOUT(1000)
    ) dut (
        .CLK            (CLK),
        .rst            (rst),
        .en             (en),
        .mode           (mode),
        .scl_in         (scl_in),
        .scl_o          (scl_o),
        .tick_low_mid   (tick_low_mid),
        .tick_high_mid  (tick_high_mid),
        .tick_fall      (tick_fall),
        .busy           (busy),
        .stretch_timeout(stretch_timeout)
    );

    typedef struct {
        logic [1:0] mode;
        int         lo;
        int         hi;
        int         lmid;
        int         hmid;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Precondition: the current sample is the first cycle of a low phase.
    // Returns phase lengths, 1-based tick positions and tick overlaps.
    task automatic run_period(output int lo, output int hi, output int lmid,
                              output int hmid, output int fall0, output int ovl);
        lo = 0; hi = 0; lmid = 0; hmid = 0; ovl = 0;
        fall0 = int'(tick_fall);
        while (scl_o == 1'b0 && lo < 3000) begin
            lo++;
            if (tick_low_mid) lmid = lo;
            if (int'(tick_fall) + int'(tick_low_mid) + int'(tick_high_mid) > 1) ovl++;
            step();
        end
        while (scl_o == 1'b1 && busy && hi < 3000) begin
            hi++;
            if (tick_high_mid) hmid = hi;
            if (int'(tick_fall) + int'(tick_low_mid) + int'(tick_high_mid) > 1) ovl++;
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        en = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        chk(name, busy, 0);
    endtask

    vec_t tbl[4];

    initial begin
        int lo, hi, lmid, hmid, fall0, ovl, n;

        tbl[0] = '{2'b00, 250, 250 + HW, 125, 125 + HW};
        tbl[1] = '{2'b01, 62, 62 + HW, 31, 31 + HW};
        tbl[2] = '{2'b10, 25, 25 + HW, 12, 12 + HW};
        tbl[3] = '{2'b11, 250, 250 + HW, 125, 125 + HW};

        // Reset state, with en high to show reset dominates.
        en = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_scl_o", scl_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ticks", {tick_fall, tick_low_mid, tick_high_mid}, 0);
        chk("rst_timeout", stretch_timeout, 0);
        step();
        step();
        chk("rst_hold_busy", busy, 0);
        en = 1'b0;
        #3 rst = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", busy, 0);

        // Period table, each run started from IDLE.
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            en = 1'b1;
            step();
            run_period(lo, hi, lmid, hmid, fall0, ovl);
            chk($sformatf("m%0d_fall", i), fall0, 1);
            chk($sformatf("m%0d_low", i), lo, tbl[i].lo);
            chk($sformatf("m%0d_high", i), hi, tbl[i].hi);
            chk($sformatf("m%0d_lowmid", i), lmid, tbl[i].lmid);
            chk($sformatf("m%0d_highmid", i), hmid, tbl[i].hmid);
            chk($sformatf("m%0d_overlap", i), ovl, 0);
            chk($sformatf("m%0d_nextfall", i), tick_fall, 1);
            wait_idle($sformatf("m%0d_idle", i));
            chk($sformatf("m%0d_park", i), scl_o, 1);
        end

        // Mode change while busy is ignored until the next IDLE exit.
        mode = 2'b10;
        en = 1'b1;
        step();
        run_period(lo, hi, lmid, hmid, fall0, ovl);
        mode = 2'b00;
        run_period(lo, hi, lmid, hmid, fall0, ovl);
        chk("mchg_low", lo, 25);
        chk("mchg_high", hi, 25 + HW);
        wait_idle("mchg_idle");
        en = 1'b1;
        step();
        run_period(lo, hi, lmid, hmid, fall0, ovl);
        chk("mchg_new_low", lo, 250);
        wait_idle("mchg_new_idle");

        // en dropped at low cycle 10: both phases still complete in full.
        mode = 2'b00;
        en = 1'b1;
        step();
        lo = 0;
        while (scl_o == 1'b0 && lo < 3000) begin
            lo++;
            if (lo == 10) en = 1'b0;
            step();
        end
        hi = 0;
        while (scl_o == 1'b1 && busy && hi < 3000) begin
            hi++;
            step();
        end
        chk("drop_low", lo, 250);
        chk("drop_high", hi, 250 + HW);
        chk("drop_busy", busy, 0);
        chk("drop_scl_o", scl_o, 1);
        n = 0;
        repeat (600) begin
            if (tick_fall || scl_o == 1'b0) n++;
            step();
        end
        chk("drop_no_fall", n, 0);

        // Reset mid-LOW releases SCL before the next edge.
        mode = 2'b10;
        en = 1'b1;
        step();
        repeat (5) step();
        chk("mid_low_scl_o", scl_o, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_scl_o", scl_o, 1);
        chk("async_busy", busy, 0);
        chk("async_ticks", {tick_fall, tick_low_mid, tick_high_mid}, 0);
        #2 rst = 1'b1;
        en = 1'b1;
        step();
        chk("rel_fall", tick_fall, 1);
        chk("rel_scl_o", scl_o, 0);
        wait_idle("rel_idle");

`ifdef SCL_STRETCH_EN
        // Stretch of 300 cycles, then a full-length high phase.
        mode = 2'b00;
        hold_low = 1'b1;
        en = 1'b1;
        step();
        lo = 0;
        while (scl_o == 1'b0 && lo < 3000) begin
            lo++;
            step();
        end
        hi = 0;
        hmid = 0;
        while (scl_o == 1'b1 && busy && hi < 3000) begin
            hi++;
            if (hi == 301) hold_low = 1'b0;
            if (tick_high_mid) hmid = hi;
            step();
        end
        chk("str_high_total", hi, 553);
        chk("str_high_mid", hmid, 303 + 125);
        chk("str_no_timeout", stretch_timeout, 0);
        wait_idle("str_idle");

        // Stuck-low SCL: timeout after 1000 wait cycles.
        hold_low = 1'b1;
        en = 1'b1;
        step();
        lo = 0;
        while (scl_o == 1'b0 && lo < 3000) begin
            lo++;
            step();
        end
        n = 0;
        while (busy && n < 3000) begin
            n++;
            step();
        end
        chk("to_wait_cycles", n, 1000);
        chk("to_flag", stretch_timeout, 1);
        chk("to_scl_o", scl_o, 1);
        chk("to_busy", busy, 0);
        en = 1'b0;
        step();
        chk("to_clear", stretch_timeout, 0);
        hold_low = 1'b0;
`else
        // Without stretch support an external low hold is ignored.
        mode = 2'b10;
        hold_low = 1'b1;
        en = 1'b1;
        step();
        run_period(lo, hi, lmid, hmid, fall0, ovl);
        chk("nostr_low", lo, 25);
        chk("nostr_high", hi, 25);
        chk("nostr_timeout", stretch_timeout, 0);
        wait_idle("nostr_idle");
        hold_low = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_scl_gen.md
I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000: input clock frequency in Hz, used to derive half-period counts.
REQ-002 Parameter STRETCH_TIMEOUT, default 1_250_000: maximum clock cycles SCL may be held low externally (25 ms at 50 MHz).
REQ-003 Port CLK, input, 1: system clock; all logic on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port en, input, 1: run request; SCL toggles while high, parks high when low.
REQ-006 Port mode, input, 2: speed select; 00 = 100 kHz, 01 = 400 kHz, 10 = 1 MHz, 11 = reserved, treated as 100 kHz.
REQ-007 Port scl_in, input, 1: SCL line level from the IO buffer "I" pin, asynchronous.
REQ-008 Port scl_o, output, 1: SCL drive to the IO buffer; 1 = release/high, 0 = drive low.
REQ-009 Port tick_low_mid, output, 1: one-cycle pulse at the middle of the low phase (SDA change point).
REQ-010 Port tick_high_mid, output, 1: one-cycle pulse at the middle of the high phase (SDA sample point).
REQ-011 Port tick_fall, output, 1: one-cycle pulse in the cycle scl_o goes 1->0.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port stretch_timeout, output, 1: sticky flag; stretch exceeded STRETCH_TIMEOUT.

Function
REQ-014 HALF = CLK_FREQ_HZ / (2 * f_mode), integer-truncated (50 MHz: 250 / 62 / 25); counter width = $clog2(max HALF)+1.
REQ-015 States: IDLE, LOW, HIGH_WAIT, HIGH.
REQ-016 IDLE: scl_o = 1, cnt = 0; en = 1 -> LOW next cycle, scl_o = 0, tick_fall = 1, mode latched.
REQ-017 mode is sampled only on IDLE->LOW; changes while busy have no effect until the next IDLE exit.
REQ-018 LOW: cnt increments each cycle; tick_low_mid = 1 when cnt == HALF/2-1; at cnt == HALF-1 -> HIGH_WAIT, cnt = 0, scl_o = 1; low phase is exactly HALF cycles.
REQ-019 HIGH_WAIT: hold until synchronised scl_in == 1, then HIGH with cnt = 0; wait cycles do not count toward HALF.
REQ-020 HIGH: cnt increments; tick_high_mid = 1 when cnt == HALF/2-1; at cnt == HALF-1: en = 1 -> LOW, cnt = 0, scl_o = 0, tick_fall = 1; en = 0 -> IDLE.
REQ-021 en deassertion mid-LOW or mid-HIGH does not truncate the phase; the current high phase always completes, so SCL never glitches.
REQ-022 scl_in is passed through a 2-flop synchroniser before use; the synchroniser flops reset to 1.
REQ-023 At most one tick output is high in any cycle.
REQ-024 Stretch counter counts HIGH_WAIT cycles; reaching STRETCH_TIMEOUT sets stretch_timeout, forces IDLE, scl_o = 1.
REQ-025 stretch_timeout clears only on IDLE with en = 0, or reset.

Reset
REQ-026 On rst = 0, immediately: state IDLE, cnt 0, scl_o 1, all ticks 0, busy 0, stretch_timeout 0, stretch counter 0.
REQ-027 Reset mid-LOW releases SCL (scl_o = 1) asynchronously, without waiting for a clock edge.
REQ-028 After rst deasserts, the first state change occurs no earlier than the first CLK edge with en = 1.

Configuration
REQ-029 Macro SCL_STRETCH_EN defined: HIGH_WAIT, synchroniser, stretch counter and stretch_timeout behave per REQ-019, REQ-022, REQ-024, REQ-025.
REQ-030 SCL_STRETCH_EN undefined: LOW -> HIGH directly, scl_in ignored, stretch logic not synthesised, stretch_timeout tied to 0.

Verification
REQ-031 50 MHz, mode 00, en held 1, scl_in = scl_o -> scl_o period 500 cycles, 250 low / 250 high; tick_low_mid at low cycle 125, tick_high_mid at high cycle 125.
REQ-032 mode 01 then mode 10, each from IDLE -> periods 124 and 50 cycles; mode change while busy -> period unchanged until IDLE.
REQ-033 SCL_STRETCH_EN defined, scl_in held 0 for 300 cycles after scl_o release -> high phase starts 2-3 cycles after scl_in rises, lasting 250 cycles.
REQ-034 SCL_STRETCH_EN defined, STRETCH_TIMEOUT = 1000, scl_in stuck 0 -> stretch_timeout = 1 after 1000 HIGH_WAIT cycles, IDLE, scl_o = 1, busy = 0.
REQ-035 en dropped at low cycle 10 -> low and high phases complete in full, then IDLE, scl_o = 1, no further tick_fall.
REQ-036 rst asserted mid-LOW -> scl_o = 1 and busy = 0 before the next CLK edge; en = 1 after release -> tick_fall on the first edge.
